// File: rtl/display_timing_pkg.sv
// Shared types and default 640x480@60 raster constants for display timing.
package display_timing_pkg;

    localparam int CNT_W     = 10;
    localparam int MAX_TOTAL = 1 << CNT_W;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    typedef enum logic [1:0] {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK} phase_t;
    typedef enum logic {ST_IDLE, ST_RUN} top_state_t;

endpackage

// File: rtl/display_timing_ctrl_axis.sv
// One raster axis: position counter plus registered phase tracking.
// The phase register steps on the same advance that crosses a boundary,
// so phase never has to be decoded from the count.
module axis_phase_counter
    import display_timing_pkg::*;
#(
    parameter int ACTIVE = DEF_H_ACTIVE,
    parameter int FP     = DEF_H_FP,
    parameter int SYNC   = DEF_H_SYNC,
    parameter int BP     = DEF_H_BP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             advance,
    input  logic             clear,
    output logic [CNT_W-1:0] count,
    output phase_t           phase,
    output logic             wrap
);

    localparam int TOTAL = ACTIVE + FP + SYNC + BP;
    localparam logic [CNT_W-1:0] LAST_ACT  = CNT_W'(ACTIVE - 1);
    localparam logic [CNT_W-1:0] LAST_FP   = CNT_W'(ACTIVE + FP - 1);
    localparam logic [CNT_W-1:0] LAST_SYNC = CNT_W'(ACTIVE + FP + SYNC - 1);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(TOTAL - 1);

    logic [CNT_W-1:0] count_nxt;
    phase_t           phase_nxt;

    // Explicit compare against TOTAL-1; the counter never relies on overflow.
    assign wrap = advance && (count == LAST);

    // Next count and next phase; clear dominates advance.
    always_comb begin
        count_nxt = count;
        phase_nxt = phase;
        if (clear) begin
            count_nxt = '0;
            phase_nxt = PH_ACTIVE;
        end else if (advance) begin
            count_nxt = wrap ? '0 : count + 1'b1;
            case (phase)
                PH_ACTIVE: if (count == LAST_ACT)  phase_nxt = PH_FRONT;
                PH_FRONT:  if (count == LAST_FP)   phase_nxt = PH_SYNC;
                PH_SYNC:   if (count == LAST_SYNC) phase_nxt = PH_BACK;
                PH_BACK:   if (count == LAST)      phase_nxt = PH_ACTIVE;
                default:                           phase_nxt = PH_ACTIVE;
            endcase
        end
    end

    // Count and phase registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            phase <= PH_ACTIVE;
        end else begin
            count <= count_nxt;
            phase <= phase_nxt;
        end
    end

endmodule

// File: rtl/display_timing_ctrl.sv
// Raster timing sequencer: turns the pixel strobe into h/v positions,
// sync pulses, the active-video qualifier and line/frame markers.
module display_timing_ctrl
    import display_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             restart,
    input  logic             pixel_tick,
    output logic [CNT_W-1:0] hcount,
    output logic [CNT_W-1:0] vcount,
    output logic             hsync,
    output logic             vsync,
    output logic             active_video,
    output logic             line_start,
    output logic             frame_start,
    output logic             running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_cfg
        $error("display_timing_ctrl: H_TOTAL/V_TOTAL exceed 10-bit counters");
    end

    top_state_t state, state_nxt;
    phase_t     h_phase, v_phase;
    logic       tick_acc, cnt_clear, h_adv, h_wrap, v_wrap, start;

    assign tick_acc  = enable && pixel_tick;
    assign start     = (state == ST_IDLE) && tick_acc;
    // Restart wins over a coincident tick; IDLE holds counters at zero.
    assign cnt_clear = (state == ST_IDLE) || restart;
    assign h_adv     = (state == ST_RUN) && tick_acc && !restart;

    // Top FSM next state: start on first accepted tick, restart returns to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (tick_acc) state_nxt = ST_RUN;
            ST_RUN:  if (restart)  state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    // Top FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    axis_phase_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
    ) u_h (
        .clk(clk), .rst(rst), .advance(h_adv), .clear(cnt_clear),
        .count(hcount), .phase(h_phase), .wrap(h_wrap)
    );

    axis_phase_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
    ) u_v (
        .clk(clk), .rst(rst), .advance(h_wrap), .clear(cnt_clear),
        .count(vcount), .phase(v_phase), .wrap(v_wrap)
    );

    // Markers are re-evaluated every edge, so they last exactly one clk and
    // drop to 0 whenever no tick is accepted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= start || h_wrap;
            frame_start <= start || (h_wrap && v_wrap);
        end
    end

    // Level outputs depend only on registers, so they move on the accepting
    // edge (or immediately on async reset) and have no input-to-output path.
    assign running      = (state == ST_RUN);
    assign hsync        = (running && h_phase == PH_SYNC) ? SYNC_POL : !SYNC_POL;
    assign vsync        = (running && v_phase == PH_SYNC) ? SYNC_POL : !SYNC_POL;
    assign active_video = running && (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);

endmodule

// File: tb/tb_display_timing_ctrl.sv
// Bench for display_timing_ctrl: table of raster landmarks, hand-written
// corner sequences and a randomized run against a tick-count reference model.
// Vertical timing is shortened so a whole frame fits in a short run.
module tb_display_timing_ctrl;

    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 12,  VF = 4,  VS = 2,  VB = 6;
    localparam int HT = HA + HF + HS + HB;   // 800
    localparam int VT = VA + VF + VS + VB;   // 24

    logic       clk = 1'b0, rst = 1'b1, enable = 1'b0, restart = 1'b0, pixel_tick = 1'b0;
    logic [9:0] hcount, vcount;
    logic       hsync, vsync, active_video, line_start, frame_start, running;

    display_timing_ctrl #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1'b0)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .restart(restart), .pixel_tick(pixel_tick),
        .hcount(hcount), .vcount(vcount), .hsync(hsync), .vsync(vsync),
        .active_video(active_video), .line_start(line_start),
        .frame_start(frame_start), .running(running)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_total = 0, n_fail_prints = 0;

    // Reference model: running flag plus the number of ticks accepted since
    // the start tick. Position and phases follow by division/modulo.
    bit m_run = 0, m_new = 0;
    int m_k = 0;

    function automatic int m_h();  return m_k % HT; endfunction
    function automatic int m_v();  return (m_k / HT) % VT; endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else if (n_fail_prints++ < 40)
            $display("FAIL %s: got %0d expected %0d (k=%0d)", name, act, exp, m_k);
    endtask

    task automatic check_model();
        int h, v;
        h = m_run ? m_h() : 0;
        v = m_run ? m_v() : 0;
        chk("hcount", hcount, h);
        chk("vcount", vcount, v);
        chk("hsync", hsync, (m_run && h >= HA + HF && h < HA + HF + HS) ? 0 : 1);
        chk("vsync", vsync, (m_run && v >= VA + VF && v < VA + VF + VS) ? 0 : 1);
        chk("active_video", active_video, (m_run && h < HA && v < VA) ? 1 : 0);
        chk("line_start", line_start, (m_new && h == 0) ? 1 : 0);
        chk("frame_start", frame_start, (m_new && h == 0 && v == 0) ? 1 : 0);
        chk("running", running, m_run);
    endtask

    // Drive one clk of inputs, advance the model at the edge, check after it.
    task automatic step(input bit r, input bit en, input bit tk, input bit rs);
        bit acc;
        rst = r; enable = en; pixel_tick = tk; restart = rs;
        @(posedge clk);
        acc = en && tk;
        m_new = 0;
        if (r) begin
            m_run = 0; m_k = 0;
        end else if (m_run && rs) begin
            m_run = 0; m_k = 0;
        end else if (!m_run) begin
            if (acc) begin m_run = 1; m_k = 0; m_new = 1; end
        end else if (acc) begin
            m_k++; m_new = 1;
        end
        #1;
        check_model();
    endtask

    // Back-to-back ticks until the model reaches tick count 'target'.
    task automatic run_to(input int target);
        for (int i = 0; i < 60000 && m_k != target; i++) step(0, 1, 1, 0);
    endtask

    typedef struct {
        int k;
        int h, v;
        bit hs, vs, av, ls, fs;
    } vec_t;
    vec_t tbl[15];

    initial begin
        tbl[0]  = '{0,          0,   0,  1, 1, 1, 1, 1};
        tbl[1]  = '{639,        639, 0,  1, 1, 1, 0, 0};
        tbl[2]  = '{640,        640, 0,  1, 1, 0, 0, 0};
        tbl[3]  = '{655,        655, 0,  1, 1, 0, 0, 0};
        tbl[4]  = '{656,        656, 0,  0, 1, 0, 0, 0};
        tbl[5]  = '{751,        751, 0,  0, 1, 0, 0, 0};
        tbl[6]  = '{752,        752, 0,  1, 1, 0, 0, 0};
        tbl[7]  = '{799,        799, 0,  1, 1, 0, 0, 0};
        tbl[8]  = '{800,        0,   1,  1, 1, 1, 1, 0};
        tbl[9]  = '{800*11+5,   5,   11, 1, 1, 1, 0, 0};
        tbl[10] = '{800*12,     0,   12, 1, 1, 0, 1, 0};
        tbl[11] = '{800*16,     0,   16, 1, 0, 0, 1, 0};
        tbl[12] = '{800*17+799, 799, 17, 1, 0, 0, 0, 0};
        tbl[13] = '{800*18,     0,   18, 1, 1, 0, 1, 0};
        tbl[14] = '{800*24,     0,   0,  1, 1, 1, 1, 1};

        // Reset held with enable and ticks running: reset values throughout.
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        // IDLE with enable low: no pulses, nothing moves.
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0);

        // Start tick, then walk the landmark table.
        step(0, 1, 1, 0);
        foreach (tbl[i]) begin
            run_to(tbl[i].k);
            chk("tbl_hcount", hcount, tbl[i].h);
            chk("tbl_vcount", vcount, tbl[i].v);
            chk("tbl_hsync", hsync, tbl[i].hs);
            chk("tbl_vsync", vsync, tbl[i].vs);
            chk("tbl_active", active_video, tbl[i].av);
            chk("tbl_line_start", line_start, tbl[i].ls);
            chk("tbl_frame_start", frame_start, tbl[i].fs);
        end

        // Freeze at (300,10): enable low for 50 ticks, then resume.
        run_to(800*24 + 800*10 + 300);
        for (int i = 0; i < 50; i++) step(0, 0, 1, 0);
        chk("freeze_h", hcount, 300);
        chk("freeze_v", vcount, 10);
        step(0, 1, 1, 0);
        chk("resume_h", hcount, 301);
        chk("resume_v", vcount, 10);

        // Restart colliding with a tick at (700,20).
        run_to(800*24 + 800*20 + 700);
        chk("pre_restart_h", hcount, 700);
        step(0, 1, 1, 1);
        chk("restart_running", running, 0);
        chk("restart_h", hcount, 0);
        chk("restart_v", vcount, 0);
        step(0, 1, 1, 0);
        chk("restart_frame_start", frame_start, 1);
        chk("restart_running2", running, 1);

        // Restart in IDLE is ignored: a coincident tick still starts.
        step(0, 1, 0, 1);
        step(0, 1, 1, 1);
        step(0, 0, 0, 1);
        chk("idle_restart_running", running, 0);
        step(0, 1, 1, 1);
        chk("idle_restart_start", running, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++)
            step(($urandom % 1000) == 0, ($urandom % 4) != 0,
                 ($urandom % 2) == 0, ($urandom % 500) == 0);

        // Async reset in the middle of H SYNC clears before the next edge.
        step(0, 1, 1, 1);
        step(0, 1, 1, 0);
        run_to(700);
        chk("mid_sync_hsync", hsync, 0);
        #3 rst = 1'b1;
        #1;
        chk("async_hsync", hsync, 1);
        chk("async_running", running, 0);
        chk("async_hcount", hcount, 0);
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/display_timing_ctrl.md
# display_timing_ctrl

Sequences raster scan timing for the display pipeline. It consumes the one-cycle pixel strobe from the timer block, which is the timer's `flag` output. From that strobe it generates horizontal and vertical position counters, sync pulses, a blanking qualifier and frame/line markers. It sits between the pixel-rate timer and the pixel fetch/output stage; downstream logic samples its outputs on `clk` cycles where `pixel_tick` was high.

## Interface
Parameters:
- `H_ACTIVE`, 640, visible pixels per line
- `H_FP`, 16, horizontal front porch (ticks)
- `H_SYNC`, 96, horizontal sync width (ticks)
- `H_BP`, 48, horizontal back porch (ticks)
- `V_ACTIVE`, 480, visible lines per frame
- `V_FP`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BP`, 33, vertical back porch (lines)
- `SYNC_POL`, 0, asserted level of `hsync`/`vsync` (0 = active-low)

Ports:
- `clk`  in  1  system clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `enable`  in  1  run qualifier; low freezes all state
- `restart`  in  1  synchronous return to IDLE
- `pixel_tick`  in  1  one-`clk` strobe per pixel (timer `flag`)
- `hcount`  out  10  pixel position in line, 0..H_TOTAL-1
- `vcount`  out  10  line position in frame, 0..V_TOTAL-1
- `hsync`  out  1  horizontal sync
- `vsync`  out  1  vertical sync
- `active_video`  out  1  high when both axes are in their active phase
- `line_start`  out  1  one-`clk` pulse when `hcount` becomes 0
- `frame_start`  out  1  one-`clk` pulse when position becomes (0,0)
- `running`  out  1  high outside IDLE

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP = 800; V_TOTAL = 525. Both must be ≤1024; otherwise elaboration fails with `$error`.
- Top FSM: IDLE and RUN.
  - IDLE: counts 0, syncs deasserted, `active_video`=0, `running`=0.
  - IDLE→RUN on the first `clk` where `enable && pixel_tick`. Position becomes (0,0) and `frame_start` and `line_start` pulse.
- In RUN, each `enable && pixel_tick` advances `hcount`.
  - When `hcount`=H_TOTAL-1, `hcount` wraps to 0, `line_start` pulses and `vcount` advances.
  - When `vcount`=V_TOTAL-1 and the line wraps, `vcount` wraps to 0 and `frame_start` also pulses.
- Per-axis phase FSM: ACTIVE → FRONT → SYNC → BACK → ACTIVE.
  - H boundaries: ACTIVE [0,639], FRONT [640,655], SYNC [656,751], BACK [752,799].
  - V boundaries are analogous in lines: [0,479], [480,489], [490,491], [492,524].
  - Phase changes on the same tick that the count crosses the boundary.
  - Phase is held in registers; it is not decoded combinationally from the count.
- `hsync` = SYNC_POL while H phase is SYNC, else !SYNC_POL. `vsync` is the same for V phase SYNC. `active_video` = H ACTIVE && V ACTIVE.
- `enable` low: ticks are ignored and every output holds, except the pulses, which are 0.
- `restart`: on the next edge, enter IDLE with IDLE outputs. It has priority over a simultaneous tick. It is ignored in IDLE.
- Wrap arithmetic is unsigned, 10 bits. Compare against TOTAL-1, never rely on overflow.

## Timing
- All outputs are registered and change only on a `clk` edge where the tick is accepted, or on restart or reset.
- Latency is 0 extra cycles: outputs reflect the new position in the cycle after the accepting edge.
- `line_start` and `frame_start` are exactly one `clk` wide, even when ticks arrive on consecutive clocks.
- Reset (async assert, sync deassert upstream): IDLE, `hcount`=`vcount`=0, `hsync`=`vsync`=!SYNC_POL, `active_video`=0, pulses 0, `running`=0.
- Reset mid-frame clears immediately, without waiting for a tick.
- Back-to-back ticks (strobe held high) advance once per `clk`.

## Structure
- `display_timing_pkg`:
  - `phase_t` enum {PH_ACTIVE, PH_FRONT, PH_SYNC, PH_BACK}
  - `top_state_t` {ST_IDLE, ST_RUN}
  - default 640×480 timing constants
  - `CNT_W`=10
- Sub-module `axis_phase_counter`, instantiated twice (H, V).
  - Parameters: ACTIVE/FP/SYNC/BP.
  - Inputs: `advance`, `clear`.
  - Outputs: `count`, `phase`, `wrap` (combinational, high when `advance` and count=TOTAL-1).
  - The H `wrap` drives the V `advance`.

## Test plan
- Reset/IDLE: assert `rst` with `enable`=1 and ticks running → all outputs at reset values; no pulses while in IDLE with `enable`=0.
- Start and hsync: first tick → (0,0) with `frame_start`=`line_start`=1 for one clk. Tick 656 → `hsync`=0. Tick 752 → `hsync`=1. `active_video` falls at `hcount`=640.
- Line/frame wrap: after 800 ticks → `hcount`=0, `vcount`=1, `line_start` pulse. `vsync` is low for `vcount` 490–491. After 420000 ticks → (0,0) and `frame_start` pulse.
- Freeze: drop `enable` at (300,100) for 50 ticks → counts are unchanged and no pulses; on resume the next tick gives (301,100).
- Restart collision: `restart`=1 and `pixel_tick`=1 together at (700,200) → next cycle IDLE with counts 0; the following tick gives (0,0) with `frame_start`.
- Async reset mid-sync: assert `rst` between clk edges during H SYNC → `hsync` goes to !SYNC_POL before the next clk edge.
